data_mem_preloader: RTL and testbench
=====================================

# data_mem_preloader

Sequential loader that sits directly upstream of the `ram_512x8` data memory. It accepts a byte-serial program/data image over a valid/ready handshake and packs the bytes big-endian into 32-bit words. It writes them into memory from address 0, then hands the memory port back to the pipeline's MEM stage. It replaces file-based preloading with a synthesizable, hardware-driven fill path.

## Interface
- `DEPTH`, 512: memory size in bytes; must be a multiple of 4.
- `ADDR_W`, 9: address width; `2**ADDR_W == DEPTH`.

Ports (name, direction, width, meaning):
- `Clk` in 1: single clock, rising edge.
- `Clr` in 1: reset, asynchronous, active-low.
- `Start` in 1: begin a load; sampled only in IDLE or DONE.
- `ByteIn` in 8: image byte.
- `ByteValid` in 1: `ByteIn` is valid.
- `ByteLast` in 1: final byte of the image; qualified by an accepted byte.
- `ByteReady` out 1: loader accepts a byte this cycle.
- `PipeEnable`, `PipeReadWrite`, `PipeSignExtend` in 1 each: MEM-stage controls.
- `PipeAddress` in `ADDR_W`: MEM-stage address.
- `PipeDataIn` in 32: MEM-stage write data.
- `PipeSize` in 2: MEM-stage size.
- `MemEnable`, `MemReadWrite`, `MemSignExtend` out 1 each: to `ram_512x8`.
- `MemAddress` out `ADDR_W`: to `ram_512x8`.
- `MemDataIn` out 32: to `ram_512x8`.
- `MemSize` out 2: to `ram_512x8`.
- `Busy` out 1: the loader owns the memory port.
- `Done` out 1: the load completed. Sticky until the next `Start` or `Clr`.
- `Overflow` out 1: the image filled memory without `ByteLast`. Sticky like `Done`.
- `ByteCount` out `ADDR_W+1`: number of bytes accepted in this load (0..`DEPTH`).

## Operation
- Memory size encoding: 00 = byte, 01 = halfword, 10 = word write, 11 = word read. `ReadWrite=1` means write.
- States: IDLE, FILL, WRITE_WORD, FLUSH, DONE.

IDLE
- `Busy=0`, `ByteReady=0`.
- All `Mem*` outputs are combinational copies of the `Pipe*` inputs.
- `Start` → FILL. On that transition: clear `Done`, `Overflow`, `ByteCount`, the base address, and the lane index.

FILL
- `Busy=1`, `ByteReady=1`.
- `MemEnable=0`; all other `Mem*` outputs are don't-care, driven 0.
- A byte is accepted on `ByteValid & ByteReady`. It goes into lane k = `ByteCount[1:0]`; lane 0 → `buf[31:24]` … lane 3 → `buf[7:0]`. `ByteCount` increments.
- Accepted byte in lane 3 → WRITE_WORD; a `ByteLast` on that byte is recorded.
- Accepted byte with `ByteLast` in lane 0..2 → FLUSH with k+1 pending bytes.

WRITE_WORD (exactly 1 cycle)
- `ByteReady=0`.
- Memory controls: `MemEnable=1`, `MemReadWrite=1`, `MemSize=10`, `MemSignExtend=0`, `MemAddress=base`, `MemDataIn=buf`.
- Afterwards `base += 4` and `buf` is cleared.
- Next state:
  - last recorded → DONE;
  - else `base` was `DEPTH-4` → DONE with `Overflow=1`;
  - else → FILL.

FLUSH (one cycle per pending byte, i = 0..n-1)
- `ByteReady=0`.
- Memory controls: `MemEnable=1`, `MemReadWrite=1`, `MemSize=00`, `MemAddress=base+i`, `MemDataIn={24'b0, byte i}`.
- After byte n-1 → DONE.

DONE
- `Done=1`, `Busy=0`, `ByteReady=0`.
- Memory port passes `Pipe*` through, as in IDLE.
- `Start` → FILL, starting a fresh load.

Boundary rules
- `Start` in FILL, WRITE_WORD or FLUSH is ignored.
- `ByteLast` without an accepted byte is ignored.
- `ByteLast` on byte 0 of an otherwise empty buffer gives a 1-cycle FLUSH.
- An image of exactly `DEPTH` bytes with `ByteLast` on the final byte ends with `Done=1`, `Overflow=0`.
- `Clr` asserted in any state: immediately returns to IDLE and clears buffer, base, lane, `ByteCount`, `Done` and `Overflow`. No further memory write is issued. The partial image already in memory is left in place.

## Timing
- Reset values:
  - state IDLE;
  - `ByteReady=0`, `Busy=0`, `Done=0`, `Overflow=0`, `ByteCount=0`;
  - `Mem*` follows `Pipe*`.
- All state changes happen on the rising edge of `Clk`. `Mem*` outputs are decoded combinationally from state and registers and are stable for the whole cycle.
- First possible byte acceptance: the cycle after `Start` is sampled.
- Steady-state throughput: one word per 5 cycles (4 accept cycles + 1 write cycle) with back-to-back `ByteValid`.
- The last write cycle precedes `Done=1` by one edge. Pipeline access is valid from the first cycle with `Done=1`.

## Test plan
1. **Reset.** Drive `Clr=0` mid-run, then release. Required: `ByteReady=0`, `Busy=0`, `Done=0`, `ByteCount=0`. `MemAddress` tracks `PipeAddress` (e.g. 0x1F0 → 0x1F0).
2. **Two full words.** `Start`, then bytes 0x11..0x88 back-to-back with `ByteLast` on 0x88. Required:
   - word write at addr 0 with data 0x11223344, size 10;
   - word write at addr 4 with data 0x55667788;
   - `Done=1`, `ByteCount=8`;
   - a subsequent pipe word read (size 11) at addr 4 returns 0x55667788.
3. **Partial flush.** Bytes 0xA1..0xA6 with `ByteLast` on 0xA6. Required:
   - word write at addr 0 with data 0xA1A2A3A4;
   - byte writes at addr 4 (0x000000A5) and addr 5 (0x000000A6);
   - `Done=1`.
4. **Handshake gaps.** `ByteValid` toggles randomly over 12 bytes. Required: memory contents equal the byte sequence exactly. No write is issued while fewer than 4 bytes are buffered (unless `ByteLast`).
5. **Overflow.** 516 bytes are offered with no `ByteLast`. Required:
   - 128 word writes, the last at addr 508;
   - then `Done=1`, `Overflow=1`, `ByteCount=512`;
   - `ByteReady=0`, so the remaining 4 bytes are never accepted.
6. **Reset mid-fill.** Drive `Clr=0` after 2 bytes. Required: no write is issued. A new `Start` with 4 bytes writes at addr 0 and `ByteCount=4`.

Source files
------------

// File: rtl/data_mem_preloader.sv
// rtl/data_mem_preloader.sv - byte-serial image loader that packs big-endian words into ram_512x8
module data_mem_preloader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    input  logic              ByteLast,
    output logic              ByteReady,
    input  logic              PipeEnable,
    input  logic              PipeReadWrite,
    input  logic              PipeSignExtend,
    input  logic [ADDR_W-1:0] PipeAddress,
    input  logic [31:0]       PipeDataIn,
    input  logic [1:0]        PipeSize,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic              MemSignExtend,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemDataIn,
    output logic [1:0]        MemSize,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow,
    output logic [ADDR_W:0]   ByteCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE_WORD,
        S_FLUSH,
        S_DONE
    } state_t;

    // Base of the final word slot; a full word written here without ByteLast means memory is full.
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(DEPTH - 4);

    state_t              state_q;
    logic [31:0]         buf_q;
    logic [31:0]         buf_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic [1:0]          lane;
    logic                last_q;
    logic [1:0]          pend_q;
    logic [1:0]          fidx_q;
    logic                done_q;
    logic                ovf_q;
    logic [7:0]          flush_byte;

    assign lane    = count_q[1:0];
    assign count_d = count_q + 1'b1;

    // Buffer contents with the incoming byte dropped into its big-endian lane.
    always_comb begin
        buf_d = buf_q;
        case (lane)
            2'd0:    buf_d[31:24] = ByteIn;
            2'd1:    buf_d[23:16] = ByteIn;
            2'd2:    buf_d[15:8]  = ByteIn;
            default: buf_d[7:0]   = ByteIn;
        endcase
    end

    // Byte of a partial word currently being flushed out as a byte write.
    always_comb begin
        case (fidx_q)
            2'd0:    flush_byte = buf_q[31:24];
            2'd1:    flush_byte = buf_q[23:16];
            2'd2:    flush_byte = buf_q[15:8];
            default: flush_byte = buf_q[7:0];
        endcase
    end

    // Loader FSM: state, packing buffer, write address and sticky status flags.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            base_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            pend_q  <= '0;
            fidx_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state_q <= S_FILL;
                        buf_q   <= '0;
                        base_q  <= '0;
                        count_q <= '0;
                        last_q  <= 1'b0;
                        fidx_q  <= '0;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (ByteValid) begin
                        buf_q   <= buf_d;
                        count_q <= count_d;
                        if (lane == 2'd3) begin
                            last_q  <= ByteLast;
                            state_q <= S_WRITE_WORD;
                        end else if (ByteLast) begin
                            pend_q  <= lane + 2'd1;
                            fidx_q  <= '0;
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_WRITE_WORD: begin
                    base_q <= base_q + ADDR_W'(4);
                    buf_q  <= '0;
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (base_q == LAST_BASE) begin
                        done_q  <= 1'b1;
                        ovf_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_FILL;
                    end
                end
                S_FLUSH: begin
                    if (fidx_q == pend_q - 2'd1) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        fidx_q <= fidx_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ByteReady = (state_q == S_FILL);
    assign Busy      = (state_q == S_FILL) || (state_q == S_WRITE_WORD) || (state_q == S_FLUSH);
    assign Done      = done_q;
    assign Overflow  = ovf_q;
    assign ByteCount = count_q;

    // Memory port mux: pipeline passthrough when idle/done, loader-driven writes otherwise.
    always_comb begin
        MemEnable     = PipeEnable;
        MemReadWrite  = PipeReadWrite;
        MemSignExtend = PipeSignExtend;
        MemAddress    = PipeAddress;
        MemDataIn     = PipeDataIn;
        MemSize       = PipeSize;
        case (state_q)
            S_FILL: begin
                MemEnable     = 1'b0;
                MemReadWrite  = 1'b0;
                MemSignExtend = 1'b0;
                MemAddress    = '0;
                MemDataIn     = '0;
                MemSize       = 2'b00;
            end
            S_WRITE_WORD: begin
                MemEnable     = 1'b1;
                MemReadWrite  = 1'b1;
                MemSignExtend = 1'b0;
                MemAddress    = base_q;
                MemDataIn     = buf_q;
                MemSize       = 2'b10;
            end
            S_FLUSH: begin
                MemEnable     = 1'b1;
                MemReadWrite  = 1'b1;
                MemSignExtend = 1'b0;
                MemAddress    = base_q + ADDR_W'(fidx_q);
                MemDataIn     = {24'b0, flush_byte};
                MemSize       = 2'b00;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_preloader.sv
// tb/tb_data_mem_preloader.sv - directed self-checking bench for data_mem_preloader
module tb_data_mem_preloader;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic              Clk = 1'b0;
    logic              Clr = 1'b0;
    logic              Start = 1'b0;
    logic [7:0]        ByteIn = '0;
    logic              ByteValid = 1'b0;
    logic              ByteLast = 1'b0;
    logic              ByteReady;
    logic              PipeEnable = 1'b0;
    logic              PipeReadWrite = 1'b0;
    logic              PipeSignExtend = 1'b0;
    logic [ADDR_W-1:0] PipeAddress = '0;
    logic [31:0]       PipeDataIn = '0;
    logic [1:0]        PipeSize = '0;
    logic              MemEnable;
    logic              MemReadWrite;
    logic              MemSignExtend;
    logic [ADDR_W-1:0] MemAddress;
    logic [31:0]       MemDataIn;
    logic [1:0]        MemSize;
    logic              Busy;
    logic              Done;
    logic              Overflow;
    logic [ADDR_W:0]   ByteCount;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] log_addr [$];
    logic [31:0]       log_data [$];
    logic [1:0]        log_size [$];

    data_mem_preloader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Clr(Clr), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
        .ByteLast(ByteLast), .ByteReady(ByteReady), .PipeEnable(PipeEnable),
        .PipeReadWrite(PipeReadWrite), .PipeSignExtend(PipeSignExtend),
        .PipeAddress(PipeAddress), .PipeDataIn(PipeDataIn), .PipeSize(PipeSize),
        .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemSignExtend(MemSignExtend),
        .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemSize(MemSize),
        .Busy(Busy), .Done(Done), .Overflow(Overflow), .ByteCount(ByteCount)
    );

    always #5 Clk = ~Clk;

    // Behavioural ram_512x8 plus a log of every write the loader issues.
    always @(posedge Clk) begin
        if (MemEnable && MemReadWrite) begin
            log_addr.push_back(MemAddress);
            log_data.push_back(MemDataIn);
            log_size.push_back(MemSize);
            if (MemSize == 2'b00) begin
                mem[MemAddress] <= MemDataIn[7:0];
            end else begin
                mem[MemAddress]          <= MemDataIn[31:24];
                mem[MemAddress + 9'd1]   <= MemDataIn[23:16];
                mem[MemAddress + 9'd2]   <= MemDataIn[15:8];
                mem[MemAddress + 9'd3]   <= MemDataIn[7:0];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_size.delete();
    endtask

    task automatic check_log(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [1:0] s);
        if (idx < log_addr.size()) begin
            check({tag, "_addr"}, 64'(log_addr[idx]), 64'(a));
            check({tag, "_data"}, 64'(log_data[idx]), 64'(d));
            check({tag, "_size"}, 64'(log_size[idx]), 64'(s));
        end else begin
            check({tag, "_missing"}, 64'(log_addr.size()), 64'(idx + 1));
        end
    endtask

    task automatic do_start();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Offer one byte until accepted or the budget expires; returns at a negedge.
    task automatic push_byte(input logic [7:0] b, input logic last, input int budget,
                             output logic acc);
        acc       = 1'b0;
        ByteIn    = b;
        ByteLast  = last;
        ByteValid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            acc = ByteReady;
            @(negedge Clk);
            if (acc) break;
        end
        ByteValid = 1'b0;
        ByteLast  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input string tag);
        logic acc;
        push_byte(b, last, 10, acc);
        if (!acc) check({tag, "_accept_timeout"}, 64'(acc), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (Done) break;
            @(negedge Clk);
        end
        if (!Done) check({tag, "_done_timeout"}, 64'(Done), 64'd1);
    endtask

    initial begin
        logic acc;
        logic [7:0] seq [12];

        // 1: reset, including reset asserted mid-load
        repeat (2) @(negedge Clk);
        Clr = 1'b1;
        do_start();
        send(8'h77, 1'b0, "t1");
        Clr = 1'b0;
        @(negedge Clk);
        Clr = 1'b1;
        PipeAddress = 9'h1F0;
        @(negedge Clk);
        check("t1_ready", 64'(ByteReady), 64'd0);
        check("t1_busy", 64'(Busy), 64'd0);
        check("t1_done", 64'(Done), 64'd0);
        check("t1_count", 64'(ByteCount), 64'd0);
        check("t1_addr_pass", 64'(MemAddress), 64'h1F0);
        PipeAddress = '0;

        // 2: two full words
        clear_log();
        do_start();
        check("t2_busy", 64'(Busy), 64'd1);
        for (int i = 0; i < 8; i++) send(8'h11 * 8'(i + 1), i == 7, "t2");
        wait_done("t2");
        check("t2_nwrites", 64'(log_addr.size()), 64'd2);
        check_log("t2_w0", 0, 9'd0, 32'h11223344, 2'b10);
        check_log("t2_w1", 1, 9'd4, 32'h55667788, 2'b10);
        check("t2_done", 64'(Done), 64'd1);
        check("t2_count", 64'(ByteCount), 64'd8);
        check("t2_busy_end", 64'(Busy), 64'd0);
        PipeEnable = 1'b1; PipeReadWrite = 1'b0; PipeSize = 2'b11; PipeAddress = 9'd4;
        @(negedge Clk);
        check("t2_pipe_size", 64'(MemSize), 64'd3);
        check("t2_pipe_read", 64'({mem[MemAddress], mem[MemAddress + 9'd1],
                                   mem[MemAddress + 9'd2], mem[MemAddress + 9'd3]}),
              64'h55667788);
        PipeEnable = 1'b0; PipeSize = 2'b00; PipeAddress = '0;

        // 3: partial flush
        clear_log();
        do_start();
        check("t3_done_cleared", 64'(Done), 64'd0);
        for (int i = 0; i < 6; i++) send(8'hA1 + 8'(i), i == 5, "t3");
        wait_done("t3");
        check("t3_nwrites", 64'(log_addr.size()), 64'd3);
        check_log("t3_w0", 0, 9'd0, 32'hA1A2A3A4, 2'b10);
        check_log("t3_b4", 1, 9'd4, 32'h000000A5, 2'b00);
        check_log("t3_b5", 2, 9'd5, 32'h000000A6, 2'b00);
        check("t3_done", 64'(Done), 64'd1);
        check("t3_count", 64'(ByteCount), 64'd6);

        // Single byte with ByteLast: one-cycle flush
        clear_log();
        do_start();
        send(8'h5A, 1'b1, "t3s");
        wait_done("t3s");
        check("t3s_nwrites", 64'(log_addr.size()), 64'd1);
        check_log("t3s_b0", 0, 9'd0, 32'h0000005A, 2'b00);

        // 4: handshake gaps
        clear_log();
        do_start();
        for (int i = 0; i < 12; i++) seq[i] = 8'h30 + 8'(i * 7);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            send(seq[i], i == 11, "t4");
            if (i % 4 != 3) check("t4_nowrite_partial", 64'(log_addr.size()), 64'(i / 4));
        end
        wait_done("t4");
        check("t4_nwrites", 64'(log_addr.size()), 64'd3);
        for (int i = 0; i < 12; i++) check("t4_mem", 64'(mem[i]), 64'(seq[i]));

        // 5: overflow with 516 bytes offered, no ByteLast
        clear_log();
        do_start();
        for (int i = 0; i < 512; i++) send(8'(i), 1'b0, "t5");
        wait_done("t5");
        check("t5_nwrites", 64'(log_addr.size()), 64'd128);
        if (log_addr.size() == 128) check("t5_last_addr", 64'(log_addr[127]), 64'd508);
        check("t5_done", 64'(Done), 64'd1);
        check("t5_ovf", 64'(Overflow), 64'd1);
        check("t5_count", 64'(ByteCount), 64'd512);
        check("t5_mem508", 64'({mem[508], mem[509], mem[510], mem[511]}), 64'hFCFDFEFF);
        for (int i = 0; i < 4; i++) begin
            push_byte(8'hEE, 1'b0, 3, acc);
            check("t5_extra_rejected", 64'(acc), 64'd0);
        end
        check("t5_count_after", 64'(ByteCount), 64'd512);

        // Exactly DEPTH bytes with ByteLast on the final byte
        clear_log();
        do_start();
        check("t5b_ovf_cleared", 64'(Overflow), 64'd0);
        for (int i = 0; i < 512; i++) send(8'(i + 3), i == 511, "t5b");
        wait_done("t5b");
        check("t5b_done", 64'(Done), 64'd1);
        check("t5b_ovf", 64'(Overflow), 64'd0);
        check("t5b_count", 64'(ByteCount), 64'd512);

        // 6: reset mid-fill
        clear_log();
        do_start();
        send(8'hC1, 1'b0, "t6");
        send(8'hC2, 1'b0, "t6");
        Clr = 1'b0;
        repeat (2) @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        check("t6_nowrite", 64'(log_addr.size()), 64'd0);
        check("t6_count_clr", 64'(ByteCount), 64'd0);
        do_start();
        for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), i == 3, "t6");
        wait_done("t6");
        check("t6_nwrites", 64'(log_addr.size()), 64'd1);
        check_log("t6_w0", 0, 9'd0, 32'hD0D1D2D3, 2'b10);
        check("t6_count", 64'(ByteCount), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
